mem_interf_sram: RTL and testbench
==================================

// Module: mem_interf_sram
// PURPOSE
//  Load/store memory subsystem: a request FSM in front of a single-port 16-bit-word SRAM.
//  Accepts one store or load from the execute stage, performs it in the SRAM, and pulses mem_done.
//  On a load it also returns the selected byte to the instruction/datapath side on datatoinst.
//  Replaces the separate interface + SRAM pair with one block; no internal bidirectional bus.
// PARAMETERS
//  ADDR_W   14  byte address width; SRAM holds 2**(ADDR_W-1) words of DATA_W bits
//  DATA_W   16  store data / SRAM word width
//  OUT_W    8   load return width (one byte)
//  MEM_LAT  1   SRAM response latency in clocks, >=1 (edges from request to mem_resp)
// PORTS
//  clk         in   1       single clock, all logic on posedge
//  reset_n     in   1       synchronous, active-high reset (codebase name kept; high = reset)
//  store       in   1       store request, sampled only in IDLE
//  load        in   1       load request, sampled only in IDLE
//  result      in   DATA_W  store data
//  addr        in   ADDR_W  byte address; addr[ADDR_W-1:1] = word, addr[0] = byte select
//  mem_done    out  1       one-cycle completion pulse for store or load
//  datatoinst  out  OUT_W   load byte, registered, held until next load completes
// BEHAVIOUR
//  Clock and reset: one clock clk; reset_n is synchronous and active-high.
//  Reset: state=IDLE, mem_done=0, datatoinst=0, internal write_req/read_req/mem_resp=0, latency counter=0.
//   Reset does not clear the SRAM array; power-up contents are undefined.
//  FSM states: IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: at the edge sampling store|load, latch addr, result and op (store has priority if both).
//   Next state is BUSY; write_req or read_req is asserted from that edge.
//  BUSY: requests are held stable. The SRAM side performs the operation.
//   A write commits the full word mem[word] <= result at the first edge that sees write_req.
//   A read registers mem[word] at that same edge.
//   mem_resp asserts MEM_LAT edges after req went high, i.e. at edge E(MEM_LAT), with E0 = accept edge.
//  BUSY -> DONE at the edge that sees mem_resp. At that edge:
//   mem_done <= 1; req and mem_resp drop.
//   For a load, datatoinst <= addr[0] ? word[15:8] : word[7:0].
//  DONE: mem_done is high for exactly one cycle; then IDLE; store/load ignored in DONE.
//  Latency: mem_done is high in the cycle after edge E(MEM_LAT+1); for MEM_LAT=1, in the 3rd cycle after accept.
//  store/load asserted in BUSY/DONE are dropped (no queue).
//   The requester holds the strobe or re-issues after mem_done.
//  Level-held strobe in IDLE re-triggers: a strobe still high in the cycle after DONE starts a new operation.
//  Stores do not change datatoinst.
//  Reset mid-operation: abort to IDLE with no mem_done.
//   A store is lost if reset is sampled at or before edge E1; otherwise the word is already written.
//  Address wrap: none; the word index is addr[ADDR_W-1:1] directly.
//   Highest word 0x1FFF is valid; word 0 and word 0x1FFF are independent.
//  Back-to-back store then load to the same address returns the newly stored data (no bypass needed; ops serialize).
// TESTING
//  Reset: hold reset_n=1 for 2 cycles -> mem_done=0, datatoinst=0x00, no SRAM write.
//  Store result=0xBEEF addr=0x0010, then load addr=0x0010 -> load returns datatoinst=0xEF;
//   load addr=0x0011 -> datatoinst=0xBE; each op gives one mem_done pulse in cycle E2+ (MEM_LAT=1).
//  store=load=1 with result=0x1234 addr=0x3FFE -> store wins; then load addr=0x3FFF -> 0x12.
//   Then load addr=0x0000 (prior store 0x5678) -> 0x78.
//  Pulse store while BUSY with other addr/data -> ignored; only the first store is visible in memory.
//   datatoinst is unchanged by stores.
//  Reset at edge E1 of a store of 0xAAAA over existing 0x5555 -> no mem_done, IDLE.
//   A later load of the low byte returns 0x55.
//  MEM_LAT=3 rebuild: load -> mem_done high exactly one cycle, in the cycle after edge E4.

Source files
------------

// File: rtl/mem_interf_sram_if.sv
`default_nettype none
// ==========================================================================
// mem_interf_sram_if : execute-stage load/store request bus | rev 1.0
// ==========================================================================
interface mem_interf_sram_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 16,
   parameter int OUT_W  = 8
);
   logic              store;
   logic              load;
   logic [DATA_W-1:0] result;
   logic [ADDR_W-1:0] addr;
   logic              mem_done;
   logic [OUT_W-1:0]  datatoinst;

   modport master (output store, load, result, addr, input mem_done, datatoinst);
   modport slave  (input store, load, result, addr, output mem_done, datatoinst);
endinterface
`default_nettype wire

// File: rtl/mem_interf_sram.sv
`default_nettype none
// ==========================================================================
// mem_interf_sram : request FSM in front of a single-port word SRAM | rev 1.0
// ==========================================================================
module mem_interf_sram #(
   parameter int ADDR_W  = 14,
   parameter int DATA_W  = 16,
   parameter int OUT_W   = 8,
   parameter int MEM_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   mem_interf_sram_if.slave     bus
);
   localparam int WORDS = 2 ** (ADDR_W - 1);
   localparam int CNT_W = $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   logic                is_store;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                write_req;
   logic                read_req;
   logic                mem_resp;
   logic [CNT_W-1:0]    lat_cnt;
   logic                mem_done_q;
   logic [OUT_W-1:0]    dti_q;

   logic [DATA_W-1:0]   mem [WORDS];
   logic [DATA_W-1:0]   rdata;
   logic [ADDR_W-2:0]   word_idx;
   logic                first_req;

   assign word_idx  = addr_q[ADDR_W-1:1];
   // The SRAM acts only on the first edge of a request; later edges just count latency.
   assign first_req = (write_req | read_req) && (lat_cnt == '0);

   always_ff @(posedge clk) begin
      if (write_req && first_req && !reset_n)
         mem[word_idx] <= wdata_q;
      if (read_req && first_req)
         rdata <= mem[word_idx];
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         state      <= IDLE;
         mem_done_q <= 1'b0;
         dti_q      <= '0;
         write_req  <= 1'b0;
         read_req   <= 1'b0;
         mem_resp   <= 1'b0;
         lat_cnt    <= '0;
      end else begin
         mem_done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.store || bus.load) begin
                  is_store  <= bus.store;
                  addr_q    <= bus.addr;
                  wdata_q   <= bus.result;
                  write_req <= bus.store;
                  read_req  <= !bus.store;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (mem_resp) begin
                  mem_done_q <= 1'b1;
                  write_req  <= 1'b0;
                  read_req   <= 1'b0;
                  mem_resp   <= 1'b0;
                  lat_cnt    <= '0;
                  if (!is_store)
                     dti_q <= addr_q[0] ? rdata[2*OUT_W-1:OUT_W] : rdata[OUT_W-1:0];
                  state      <= DONE;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
                  if (lat_cnt == CNT_W'(MEM_LAT - 1))
                     mem_resp <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mem_done   = mem_done_q;
   assign bus.datatoinst = dti_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_interf_sram.sv
`default_nettype none
// ==========================================================================
// tb_mem_interf_sram : checks MEM_LAT=1 and MEM_LAT=3 builds side by side | rev 1.0
// ==========================================================================
module tb_mem_interf_sram;
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int   passed = 0;
   int   total  = 0;

   mem_interf_sram_if #(.ADDR_W(14), .DATA_W(16), .OUT_W(8)) if1 ();
   mem_interf_sram_if #(.ADDR_W(14), .DATA_W(16), .OUT_W(8)) if3 ();

   mem_interf_sram #(.ADDR_W(14), .DATA_W(16), .OUT_W(8), .MEM_LAT(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(if1.slave));
   mem_interf_sram #(.ADDR_W(14), .DATA_W(16), .OUT_W(8), .MEM_LAT(3)) dut3 (
      .clk(clk), .reset_n(reset_n), .bus(if3.slave));

   always #5 clk = ~clk;

   // Reference model: word-addressed memory contents and last returned byte.
   logic [15:0] mdl [int];
   int          written [$];
   logic [7:0]  exp_dti = 8'h00;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic drive(input bit st, input bit ld, input logic [13:0] a, input logic [15:0] d);
      if1.store = st; if1.load = ld; if1.addr = a; if1.result = d;
      if3.store = st; if3.load = ld; if3.addr = a; if3.result = d;
   endtask

   task automatic model_op(input bit st, input bit ld, input logic [13:0] a, input logic [15:0] d);
      int w;
      w = int'(a[13:1]);
      if (st) begin
         mdl[w] = d;
         written.push_back(w);
      end else if (ld) begin
         exp_dti = a[0] ? mdl[w][15:8] : mdl[w][7:0];
      end
   endtask

   // Called at a negedge with both DUTs idle; returns at a negedge with both idle.
   task automatic run_op(input string tag, input bit st, input bit ld, input logic [13:0] a,
                         input logic [15:0] d, input bit poke, input logic [13:0] pa,
                         input logic [15:0] pd);
      logic [7:0] p1, p3;
      drive(st, ld, a, d);
      @(negedge clk);
      if (poke) drive(1'b1, 1'b0, pa, pd);
      else      drive(1'b0, 1'b0, a, d);
      p1[0] = if1.mem_done; p3[0] = if3.mem_done;
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         if (k == 1) drive(1'b0, 1'b0, a, d);
         p1[k] = if1.mem_done; p3[k] = if3.mem_done;
      end
      model_op(st, ld, a, d);
      check({tag, ".done1"}, {8'h00, p1}, 16'h0004);
      check({tag, ".done3"}, {8'h00, p3}, 16'h0010);
      check({tag, ".dti1"},  {8'h00, if1.datatoinst}, {8'h00, exp_dti});
      check({tag, ".dti3"},  {8'h00, if3.datatoinst}, {8'h00, exp_dti});
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  p1, p3;
      logic        any_done;
      logic [13:0] ra;
      logic [15:0] rd;
      bit          rst, rl;

      drive(1'b0, 1'b0, 14'h0, 16'h0);
      repeat (2) @(negedge clk);
      check("rst.done1", {15'h0, if1.mem_done}, 16'h0);
      check("rst.done3", {15'h0, if3.mem_done}, 16'h0);
      check("rst.dti1",  {8'h00, if1.datatoinst}, 16'h0);
      check("rst.dti3",  {8'h00, if3.datatoinst}, 16'h0);
      reset_n = 1'b0;
      @(negedge clk);

      run_op("st_beef",  1, 0, 14'h0010, 16'hBEEF, 0, 14'h0, 16'h0);
      run_op("ld_lo",    0, 1, 14'h0010, 16'h0000, 0, 14'h0, 16'h0);
      run_op("ld_hi",    0, 1, 14'h0011, 16'h0000, 0, 14'h0, 16'h0);
      run_op("st_top",   1, 1, 14'h3FFE, 16'h1234, 0, 14'h0, 16'h0);
      run_op("st_zero",  1, 0, 14'h0000, 16'h5678, 0, 14'h0, 16'h0);
      run_op("ld_top_h", 0, 1, 14'h3FFF, 16'h0000, 0, 14'h0, 16'h0);
      run_op("ld_zero",  0, 1, 14'h0000, 16'h0000, 0, 14'h0, 16'h0);
      run_op("ld_top_l", 0, 1, 14'h3FFE, 16'h0000, 0, 14'h0, 16'h0);

      // A store strobed while busy must be dropped.
      run_op("st_3333",  1, 0, 14'h0022, 16'h3333, 0, 14'h0, 16'h0);
      run_op("st_poke",  1, 0, 14'h0020, 16'h1111, 1, 14'h0022, 16'h2222);
      run_op("ld_20",    0, 1, 14'h0020, 16'h0000, 0, 14'h0, 16'h0);
      run_op("ld_22",    0, 1, 14'h0022, 16'h0000, 0, 14'h0, 16'h0);

      // Level-held strobe: the fast build retriggers right after DONE, the slow one does not.
      drive(1'b1, 1'b0, 14'h0050, 16'h4242);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         p1[k] = if1.mem_done; p3[k] = if3.mem_done;
         if (k == 4) drive(1'b0, 1'b0, 14'h0050, 16'h4242);
      end
      model_op(1'b1, 1'b0, 14'h0050, 16'h4242);
      check("held.done1", {8'h00, p1}, 16'h0044);
      check("held.done3", {8'h00, p3}, 16'h0010);
      run_op("ld_held",  0, 1, 14'h0051, 16'h0000, 0, 14'h0, 16'h0);

      // Reset sampled at E1 of a store aborts it before the write.
      run_op("st_5555",  1, 0, 14'h0040, 16'h5555, 0, 14'h0, 16'h0);
      drive(1'b1, 1'b0, 14'h0040, 16'hAAAA);
      @(negedge clk);
      drive(1'b0, 1'b0, 14'h0040, 16'hAAAA);
      reset_n  = 1'b1;
      any_done = 1'b0;
      repeat (2) begin
         @(negedge clk);
         any_done |= if1.mem_done | if3.mem_done;
      end
      reset_n = 1'b0;
      repeat (6) begin
         @(negedge clk);
         any_done |= if1.mem_done | if3.mem_done;
      end
      exp_dti = 8'h00;
      check("abort.done", {15'h0, any_done}, 16'h0);
      check("abort.dti1", {8'h00, if1.datatoinst}, 16'h0);
      check("abort.dti3", {8'h00, if3.datatoinst}, 16'h0);
      run_op("ld_abort", 0, 1, 14'h0040, 16'h0000, 0, 14'h0, 16'h0);

      for (int i = 0; i < 16; i++) begin
         if (written.size() == 0 || $urandom_range(1, 0) == 1) begin
            rst = 1'b1;
            rl  = 1'($urandom_range(1, 0));
            ra  = 14'($urandom);
            rd  = 16'($urandom);
         end else begin
            rst = 1'b0;
            rl  = 1'b1;
            ra  = {13'(written[$urandom_range(written.size() - 1, 0)]), 1'($urandom_range(1, 0))};
            rd  = 16'($urandom);
         end
         run_op($sformatf("rnd%0d", i), rst, rl, ra, rd, 0, 14'h0, 16'h0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
`default_nettype wire
